// File: rtl/param_stream_pkg.sv
// param_stream_pkg: shared state type, frame counter width and depth helper for param_stream_sink
package param_stream_pkg;
  typedef enum logic {FILL, FULL} sink_state_t;
  localparam int FRAME_COUNT_WIDTH = 16;
  function automatic int depth_of(input int dims, input int pars);
    return dims / pars;
  endfunction
endpackage

// File: rtl/param_stream_sink_ram.sv
// param_stream_sink_ram: simple dual-port read-first RAM with a two-stage registered read
// ports: clk, rst (clears read pipeline only), we/wr_addr/wr_data write port,
//        rd_addr read address, rd_data word read two cycles after rd_addr is sampled
module param_stream_sink_ram
  import param_stream_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int MEM_SIZE = 8,
  parameter int AWIDTH = $clog2(MEM_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);
  localparam int IW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
  logic [DWIDTH-1:0] mem [MEM_SIZE];
  logic [DWIDTH-1:0] q0;
  // Range guards keep out-of-range addresses from touching storage.
  always_ff @(posedge clk) begin
    if (we && wr_addr < AWIDTH'(MEM_SIZE)) mem[wr_addr[IW-1:0]] <= wr_data;
  end
  // Reading the array with non-blocking semantics gives old contents on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0 <= '0;
      rd_data <= '0;
    end else begin
      q0 <= rd_addr < AWIDTH'(MEM_SIZE) ? mem[rd_addr[IW-1:0]] : '0;
      rd_data <= q0;
    end
  end
endmodule

// File: rtl/param_stream_sink.sv
// param_stream_sink: captures a valid/ready stream of parallel elements into RAM, one frame at a time
// ports: clk, rst; data_in/data_in_valid/data_in_ready input stream; clear restarts the fill;
//        fill_level, frame_done, frame_count status; rd_addr/rd_en -> rd_data/rd_valid latency-2 read
module param_stream_sink
  import param_stream_pkg::*;
#(
  parameter int DATA_TENSOR_SIZE_DIM_0 = 32,
  parameter int DATA_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_PRECISION_0 = 16,
  parameter int DATA_PARALLELISM_DIM_0 = 4,
  parameter int DATA_PARALLELISM_DIM_1 = 1,
  parameter int STOP_ON_FULL = 1,
  parameter int IN_DEPTH = depth_of(DATA_TENSOR_SIZE_DIM_0 * DATA_TENSOR_SIZE_DIM_1,
                                    DATA_PARALLELISM_DIM_0 * DATA_PARALLELISM_DIM_1),
  parameter int ADDR_WIDTH = $clog2(IN_DEPTH + 1)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [DATA_PRECISION_0-1:0]                     data_in [DATA_PARALLELISM_DIM_0*DATA_PARALLELISM_DIM_1],
  input  logic                                            data_in_valid,
  output logic                                            data_in_ready,
  input  logic                                            clear,
  output logic [ADDR_WIDTH-1:0]                           fill_level,
  output logic                                            frame_done,
  output logic [FRAME_COUNT_WIDTH-1:0]                    frame_count,
  input  logic [ADDR_WIDTH-1:0]                           rd_addr,
  input  logic                                            rd_en,
  output logic [DATA_PRECISION_0*DATA_PARALLELISM_DIM_0*DATA_PARALLELISM_DIM_1-1:0] rd_data,
  output logic                                            rd_valid
);
  localparam int NE = DATA_PARALLELISM_DIM_0 * DATA_PARALLELISM_DIM_1;
  localparam int W = DATA_PRECISION_0 * NE;
  sink_state_t state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [W-1:0] word;
  logic [1:0] rd_pipe;
  logic xfer, last;
  always_comb begin
    word = '0;
    for (int j = 0; j < NE; j++) word[DATA_PRECISION_0*j +: DATA_PRECISION_0] = data_in[j];
  end
  // clear gates ready combinationally so a coincident beat is never written.
  assign data_in_ready = !rst && state == FILL && !clear;
  assign xfer = data_in_valid && data_in_ready;
  assign last = wr_ptr == ADDR_WIDTH'(IN_DEPTH - 1);
  assign fill_level = wr_ptr;
  assign rd_valid = rd_pipe[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      wr_ptr <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
      rd_pipe <= '0;
    end else begin
      rd_pipe <= {rd_pipe[0], rd_en};
      frame_done <= xfer && last;
      if (clear) begin
        state <= FILL;
        wr_ptr <= '0;
      end else if (xfer) begin
        wr_ptr <= last ? '0 : wr_ptr + 1'b1;
        if (last) frame_count <= frame_count + 1'b1;
        if (last && STOP_ON_FULL != 0) state <= FULL;
      end
    end
  end
  param_stream_sink_ram #(.DWIDTH(W), .MEM_SIZE(IN_DEPTH), .AWIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(xfer),
    .wr_addr(wr_ptr),
    .wr_data(word),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_param_stream_sink.sv
// tb_param_stream_sink: directed table-driven bench for param_stream_sink (hold and wrap variants)
module tb_param_stream_sink;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] din [4];
  logic valid, ready, clear, done, rd_en, rd_valid;
  logic [3:0] fill, rd_addr;
  logic [15:0] count;
  logic [63:0] rd_data;
  logic [15:0] w_din [4];
  logic w_valid, w_ready, w_clear, w_done, w_rd_en, w_rd_valid;
  logic [3:0] w_fill, w_rd_addr;
  logic [15:0] w_count;
  logic [63:0] w_rd_data;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    bit sel;
    bit valid;
    bit clear;
    int k;
    bit rdy;
    int fill;
    bit done;
    int cnt;
  } vec_t;
  vec_t v1 [10];
  vec_t v2 [4];
  vec_t v3 [20];

  always #5 clk = ~clk;

  param_stream_sink #(.STOP_ON_FULL(1)) dut (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(valid), .data_in_ready(ready),
    .clear(clear), .fill_level(fill), .frame_done(done), .frame_count(count),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid)
  );
  param_stream_sink #(.STOP_ON_FULL(0)) dut_w (
    .clk(clk), .rst(rst), .data_in(w_din), .data_in_valid(w_valid), .data_in_ready(w_ready),
    .clear(w_clear), .fill_level(w_fill), .frame_done(w_done), .frame_count(w_count),
    .rd_addr(w_rd_addr), .rd_en(w_rd_en), .rd_data(w_rd_data), .rd_valid(w_rd_valid)
  );

  function automatic logic [63:0] word(input int k);
    logic [63:0] w;
    for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(256 * k + j);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_beat(input bit sel, input int k, input bit v);
    for (int j = 0; j < 4; j++) begin
      if (sel) w_din[j] = 16'(256 * k + j);
      else din[j] = 16'(256 * k + j);
    end
    if (sel) w_valid = v;
    else valid = v;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    set_beat(v.sel, v.k, v.valid);
    if (v.sel) w_clear = v.clear;
    else clear = v.clear;
    #1;
    chk("vec_ready", v.sel ? w_ready : ready, v.rdy);
    @(posedge clk);
    #1;
    chk("vec_fill", v.sel ? w_fill : fill, v.fill);
    chk("vec_done", v.sel ? w_done : done, v.done);
    chk("vec_count", v.sel ? w_count : count, v.cnt);
  endtask

  task automatic send(input bit sel, input int k);
    int n;
    n = 0;
    @(negedge clk);
    set_beat(sel, k, 1'b1);
    #1;
    while (!(sel ? w_ready : ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 20) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    if (sel) w_valid = 1'b0;
    else valid = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic rd(input bit sel, input int a, input int k);
    @(negedge clk);
    if (sel) begin w_rd_en = 1'b1; w_rd_addr = 4'(a); end
    else begin rd_en = 1'b1; rd_addr = 4'(a); end
    @(negedge clk);
    if (sel) w_rd_en = 1'b0;
    else rd_en = 1'b0;
    chk("rd_valid_t1", sel ? w_rd_valid : rd_valid, 1'b0);
    @(negedge clk);
    chk("rd_valid_t2", sel ? w_rd_valid : rd_valid, 1'b1);
    chk("rd_data", sel ? w_rd_data : rd_data, word(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    v1 = '{
      '{0, 1, 0, 0, 1, 1, 0, 0},
      '{0, 1, 0, 1, 1, 2, 0, 0},
      '{0, 1, 0, 2, 1, 3, 0, 0},
      '{0, 1, 0, 3, 1, 4, 0, 0},
      '{0, 1, 0, 4, 1, 5, 0, 0},
      '{0, 1, 0, 5, 1, 6, 0, 0},
      '{0, 1, 0, 6, 1, 7, 0, 0},
      '{0, 1, 0, 7, 1, 0, 1, 1},
      '{0, 1, 0, 8, 0, 0, 0, 1},
      '{0, 0, 0, 9, 0, 0, 0, 1}
    };
    v2 = '{
      '{0, 0, 1, 0, 0, 0, 0, 2},
      '{0, 1, 0, 'h40, 1, 1, 0, 2},
      '{0, 1, 1, 'h41, 0, 0, 0, 2},
      '{0, 1, 0, 'h41, 1, 1, 0, 2}
    };
    for (int k = 0; k < 20; k++) v3[k] = '{1, 1, 0, k, 1, (k + 1) % 8, (k + 1) % 8 == 0, (k + 1) / 8};
    rst = 1'b1; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    w_clear = 1'b0; w_rd_en = 1'b0; w_rd_addr = '0;
    set_beat(0, 0, 1'b0);
    set_beat(1, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_fill", fill, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready, 1'b1);

    for (int i = 0; i < 20; i++) apply(v3[i]);
    w_valid = 1'b0;
    for (int a = 0; a < 4; a++) rd(1, a, 16 + a);
    chk("wrap_fill", w_fill, 4);
    chk("wrap_count", w_count, 2);

    for (int i = 0; i < 10; i++) apply(v1[i]);
    valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("b2b_valid", rd_valid, c >= 2);
      if (c >= 2) chk("b2b_data", rd_data, word(c - 2));
      rd_en = c < 8;
      rd_addr = 4'(c);
    end
    @(negedge clk);
    chk("b2b_valid_end", rd_valid, 1'b0);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("ready_after_clear", ready, 1'b1);
    for (int k = 'h20; k < 'h23; k++) begin gap(); send(0, k); end
    chk("partial_fill", fill, 3);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_fill", fill, 0);
    for (int k = 'h30; k < 'h38; k++) begin gap(); send(0, k); end
    chk("refill_done", done, 1'b1);
    chk("refill_fill", fill, 0);
    chk("refill_count", count, 2);
    chk("refill_ready", ready, 1'b0);
    for (int a = 0; a < 8; a++) rd(0, a, 'h30 + a);

    for (int i = 0; i < 4; i++) apply(v2[i]);
    valid = 1'b0;
    clear = 1'b0;
    rd(0, 0, 'h41);

    send(0, 'h42);
    @(negedge clk);
    set_beat(0, 'h43, 1'b1);
    rd_en = 1'b1;
    rd_addr = 4'd2;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    chk("rdw_old_valid", rd_valid, 1'b1);
    chk("rdw_old_data", rd_data, word('h32));
    @(negedge clk);
    chk("rdw_new_valid", rd_valid, 1'b1);
    chk("rdw_new_data", rd_data, word('h43));
    chk("rdw_fill", fill, 3);

    send(0, 'h44);
    send(0, 'h45);
    chk("pre_rst_fill", fill, 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rd_valid", rd_valid, 1'b0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    send(0, 'h46);
    chk("post_rst_fill", fill, 1);
    chk("post_rst_count", count, 0);
    rd(0, 0, 'h46);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
